// File: rtl/servo_motion_sequencer.sv
// ---------------------------------------------------------------------------
// servo_motion_sequencer
//
// Purpose:
//   Rate-limited motion controller placed in front of a 4-channel PWM servo
//   block. Target angles arrive over a valid/ready command port. Once per PWM
//   frame each servo's current angle moves toward its target by at most STEP
//   degrees. The PWM block is reloaded with a single-cycle strobe, and only on
//   frames where something actually changed.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      synchronous active-low reset
//   cmd_valid_i  command present
//   cmd_ready_o  command accepted when cmd_valid_i && cmd_ready_o at posedge
//   cmd_servo_i  servo select, 0..3 map to angle1_o..angle4_o
//   cmd_angle_i  target angle in degrees, clamped to MAX_ANGLE
//   angle1_o..angle4_o  registered current angles toward the PWM block
//   nextangle_o  one-cycle load strobe toward the PWM block
//   busy_o       some servo is off target, or the initial load is pending
//   done_o       one-cycle pulse when the last moving servo arrives
// ---------------------------------------------------------------------------
module servo_motion_sequencer #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP         = 2,
    parameter int MAX_ANGLE    = 180,
    parameter int HOME_ANGLE   = 90
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_servo_i,
    input  logic [7:0] cmd_angle_i,
    output logic [7:0] angle1_o,
    output logic [7:0] angle2_o,
    output logic [7:0] angle3_o,
    output logic [7:0] angle4_o,
    output logic       nextangle_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int               CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [7:0]       STEP_A   = 8'(STEP);
    localparam logic [7:0]       MAX_A    = 8'(MAX_ANGLE);
    localparam logic [7:0]       HOME_A   = 8'(HOME_ANGLE);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        UPDATE = 2'd1,
        LOAD   = 2'd2
    } stateT;

    stateT            state_q, state_d;
    logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
    logic [7:0]       cur_q [4];
    logic [7:0]       cur_d [4];
    logic [7:0]       tgt_q [4];
    logic [7:0]       tgt_d [4];
    logic             initPend_q, initPend_d;
    logic             done_q, done_d;

    logic             tick;
    logic             cmdAccept;
    logic [7:0]       cmdAngleClamped;
    logic             anyDiff;
    logic             pendingNext;

    assign tick      = (frameCnt_q == CNT_LAST);
    assign cmdAccept = cmd_valid_i && cmd_ready_o;

    // The frame counter free-runs and is independent of the FSM, so ticks
    // stay evenly spaced whether or not a frame carries an update.
    always_comb begin
        frameCnt_d = tick ? '0 : frameCnt_q + 1'b1;
    end

    // Target update: an accepted command simply overwrites its servo's
    // target. Commands are never accepted in UPDATE, so targets are stable
    // while the step is being computed.
    always_comb begin
        cmdAngleClamped = (cmd_angle_i > MAX_A) ? MAX_A : cmd_angle_i;
        for (int i = 0; i < 4; i++) begin
            tgt_d[i] = tgt_q[i];
            if (cmdAccept && (cmd_servo_i == 2'(i))) begin
                tgt_d[i] = cmdAngleClamped;
            end
        end
    end

    // Per-servo step toward target. Comparing unsigned magnitudes in each
    // direction avoids any wrap: angles never exceed 180 and STEP never
    // exceeds 75, so cur +/- STEP stays within 8 bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cur_d[i] = cur_q[i];
            if (state_q == UPDATE) begin
                if (tgt_q[i] >= cur_q[i]) begin
                    if ((tgt_q[i] - cur_q[i]) <= STEP_A) begin
                        cur_d[i] = tgt_q[i];
                    end else begin
                        cur_d[i] = cur_q[i] + STEP_A;
                    end
                end else begin
                    if ((cur_q[i] - tgt_q[i]) <= STEP_A) begin
                        cur_d[i] = tgt_q[i];
                    end else begin
                        cur_d[i] = cur_q[i] - STEP_A;
                    end
                end
            end
        end
    end

    // Difference flags. pendingNext looks at the targets as they will be
    // after this cycle, so a command landing in the tick cycle is picked up
    // by that frame's update, and one landing in LOAD suppresses done.
    always_comb begin
        anyDiff     = 1'b0;
        pendingNext = 1'b0;
        for (int i = 0; i < 4; i++) begin
            anyDiff     = anyDiff     | (cur_q[i] != tgt_q[i]);
            pendingNext = pendingNext | (cur_q[i] != tgt_d[i]);
        end
    end

    // Init-load flag and done pulse. done is registered from the LOAD cycle,
    // so it always lands one cycle after nextangle and never alongside it.
    always_comb begin
        initPend_d = (state_q == LOAD) ? 1'b0 : initPend_q;
        done_d     = (state_q == LOAD) && !pendingNext;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a frame runs UPDATE then LOAD only when there is
    // something to send to the PWM block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (tick && (initPend_q || pendingNext)) state_d = UPDATE;
            UPDATE:  state_d = LOAD;
            LOAD:    state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // FSM outputs: the command port stalls only while the step is computed,
    // and the load strobe is simply the LOAD state.
    always_comb begin
        cmd_ready_o = 1'b1;
        nextangle_o = 1'b0;
        case (state_q)
            UPDATE:  cmd_ready_o = 1'b0;
            LOAD:    nextangle_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers. Reset returns every servo to home and drops all
    // targets, so a reset mid-motion discards any move in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frameCnt_q <= '0;
            initPend_q <= 1'b1;
            done_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cur_q[i] <= HOME_A;
                tgt_q[i] <= HOME_A;
            end
        end else begin
            frameCnt_q <= frameCnt_d;
            initPend_q <= initPend_d;
            done_q     <= done_d;
            for (int i = 0; i < 4; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
            end
        end
    end

    assign angle1_o = cur_q[0];
    assign angle2_o = cur_q[1];
    assign angle3_o = cur_q[2];
    assign angle4_o = cur_q[3];
    assign busy_o   = anyDiff || initPend_q;
    assign done_o   = done_q;

endmodule

// File: doc/servo_motion_sequencer.md
Name: servo_motion_sequencer

Overview:
- Rate-limited motion controller that sits in front of the 4-channel PWM servo block.
- Accepts per-servo target angles over a valid/ready command port.
- Once per 20 ms PWM frame, steps each servo's current angle toward its target by at most STEP degrees.
- Drives angle1..angle4 and issues a single-cycle nextangle load pulse, so the PWM block is reloaded only on frame boundaries and only when something changed.

Parameters:
- FRAME_CYCLES, 1000000, clk cycles per PWM frame (20 ms at 50 MHz); the bench uses 100.
- STEP, 2, maximum angle change per servo per frame, in degrees; legal range 1..75.
- MAX_ANGLE, 180, command clamp ceiling, in degrees.
- HOME_ANGLE, 90, angle of every servo after reset.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset; synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge clk.
- cmd_servo  input  2  servo select; 0..3 map to angle1..angle4.
- cmd_angle  input  8  target angle in degrees; clamped to MAX_ANGLE.
- angle1..angle4  output  8 each  current commanded angles to the PWM block; registered.
- nextangle  output  1  one-cycle load strobe to the PWM block.
- busy  output  1  high while any current angle != its target, or while the initial load is pending.
- done  output  1  one-cycle pulse when the last outstanding servo reaches its target.

Behaviour:
- Reset (rst_n low at posedge):
  - cur[i] = tgt[i] = HOME_ANGLE; angleN = HOME_ANGLE.
  - frame_cnt = 0; state = WAIT; nextangle = 0; done = 0; cmd_ready = 1.
  - init_pend = 1, busy = 1.
  - Reset mid-motion discards all targets and any in-flight update.
- Frame counter: free-running 0..FRAME_CYCLES-1, wrapping to 0. tick = (frame_cnt == FRAME_CYCLES-1).
- FSM states: WAIT, UPDATE, LOAD.
  - WAIT: on tick, if init_pend or any cur != tgt, go to UPDATE; otherwise stay in WAIT.
  - UPDATE, one cycle: for each i, d = tgt - cur (signed 9-bit).
    - If |d| <= STEP: cur = tgt.
    - Otherwise: cur = cur ± STEP, toward tgt.
    - angleN registers take the new cur at the end of this cycle. Go to LOAD.
  - LOAD, one cycle: nextangle = 1; angleN are stable and already hold the new values. Clear init_pend.
    - If all cur == tgt and no command was accepted in UPDATE/LOAD that changes a target, assert done = 1 in the cycle after LOAD.
    - Go to WAIT.
- Timing: nextangle rises exactly 2 cycles after the tick cycle. There is exactly one nextangle pulse per frame at most, and none in frames with no change.
- Command port:
  - cmd_ready = 0 only in UPDATE; 1 in WAIT and LOAD.
  - Accepted command sets tgt[cmd_servo] = min(cmd_angle, MAX_ANGLE).
  - A later command to the same servo overwrites the target; there is no queueing.
  - A command accepted in LOAD takes effect at the next tick.
  - A command accepted in the tick cycle itself is seen by that frame's UPDATE.
- Arithmetic: STEP <= 75 and cur, tgt <= 180 guarantee no 8-bit overflow. Angles are unsigned.
- busy: combinational OR of (cur[i] != tgt[i]) over i, OR init_pend. It falls in the cycle after the final UPDATE.
- done: never asserted in the same cycle as nextangle. It is not asserted when a command sets a target equal to the current angle while not busy.

Test Plan (FRAME_CYCLES = 100, STEP = 2):
1. Reset release: hold rst_n low 5 cycles, then release → angle1..4 = 90, busy = 1. First nextangle pulse occurs 2 cycles after the first tick, with angles still 90. busy falls, done pulses once, and no further nextangle occurs for 3 frames.
2. Single move: cmd servo 0 to 96 → angle1 goes 92, 94, 96 on three successive frame loads, each with one nextangle pulse. done pulses after the 96 load; angle2..4 stay at 90.
3. Clamp and odd remainder: cmd servo 1 to 200 → tgt = 180. angle2 steps 92..180 over 45 frames. Then cmd servo 1 to 177 → angle2 reads 178, then 177 (last step 1).
4. Command collisions: present cmd_valid during UPDATE → cmd_ready = 0, command held and accepted next cycle. Two back-to-back commands to servo 2 (100, then 80) → only 80 is pursued; angle3 moves 88, 86, ... down to 80.
5. Simultaneous moves: servos 0..3 to 0, 180, 90, 95 → all move in parallel, one nextangle per frame. done pulses once, after frame 45.
6. Reset mid-move: assert rst_n low while angle1 = 60, heading to 0 → angles return to 90 next cycle, nextangle = 0, the target is discarded, and the init-load sequence of scenario 1 repeats.
